aes_key_sched_ctrl: RTL

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

---
 rtl/aes_pkg.sv | 38 +++
 rtl/aes_rk_buffer.sv | 37 +++
 rtl/aes_key_sched_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared constants, state encoding and round-constant table for the AES-128
// key-schedule controller.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int NUM_KEYS   = 11;

    localparam logic [3:0] FIRST_RND    = 4'd1;
    localparam logic [3:0] LAST_RND     = 4'd10;
    localparam logic [3:0] LAST_KEY_IDX = 4'd10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPAND  = 2'd1,
        CAPTURE = 2'd2,
        READY   = 2'd3
    } aes_state_t;

    // Round constants for rounds 1..10; anything else yields zero.
    function automatic logic [7:0] rcon_byte(input logic [3:0] rnd);
        logic [7:0] v;
        case (rnd)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/aes_rk_buffer.sv
// 11 x 128-bit round-key store: one write port, one registered read port,
// plus a direct view of entry 0 for the first expansion round.
module aes_rk_buffer
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_we,
    input  logic [3:0]   i_waddr,
    input  logic [127:0] i_wdata,
    input  logic [3:0]   i_raddr,
    output logic [127:0] o_rdata,
    output logic [127:0] o_key0
);

    logic [127:0] r_mem [NUM_KEYS];
    logic [127:0] r_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_we && (i_waddr <= LAST_KEY_IDX)) begin
                r_mem[i_waddr] <= i_wdata;
            end
            // Out-of-range indices read as zero rather than aliasing.
            r_rdata <= (i_raddr <= LAST_KEY_IDX) ? r_mem[i_raddr] : '0;
        end
    end

    assign o_rdata = r_rdata;
    assign o_key0  = r_mem[0];

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: feeds an external round datapath for ten
// rounds and collects the eleven round keys into the buffer.
module aes_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         ke_start,
    output logic [31:0]  ke_rc,
    output logic [127:0] ke_in,
    input  logic [127:0] ke_key,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data,
    output logic         keys_valid,
    output logic         done,
    output aes_state_t   o_dbg_state
);

    aes_state_t   r_state;
    aes_state_t   w_next_state;
    logic [3:0]   r_rnd;
    logic [3:0]   w_next_rnd;
    logic         r_keys_valid;
    logic         r_done;
    logic         w_accept;
    logic         w_we;
    logic [3:0]   w_waddr;
    logic [127:0] w_wdata;
    logic [127:0] w_key0;

    // Handshake: a key transfers on any rising edge where key_valid and
    // key_ready are both high; key_ready is high only in IDLE and READY.
    always_comb begin
        w_next_state = r_state;
        w_next_rnd   = r_rnd;
        w_accept     = 1'b0;
        w_we         = 1'b0;
        w_waddr      = '0;
        w_wdata      = '0;
        key_ready    = 1'b0;
        ke_start     = 1'b0;
        ke_rc        = '0;
        ke_in        = '0;

        case (r_state)
            IDLE, READY: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    w_accept     = 1'b1;
                    w_we         = 1'b1;
                    w_waddr      = 4'd0;
                    w_wdata      = key_in;
                    w_next_rnd   = FIRST_RND;
                    w_next_state = EXPAND;
                end
            end
            EXPAND: begin
                ke_start = 1'b1;
                ke_rc    = {rcon_byte(r_rnd), 24'h0};
                ke_in    = (r_rnd == FIRST_RND) ? w_key0 : ke_key;
                // ke_key holds the key produced by the previous round.
                if (r_rnd != FIRST_RND) begin
                    w_we    = 1'b1;
                    w_waddr = r_rnd - 4'd1;
                    w_wdata = ke_key;
                end
                w_next_rnd = r_rnd + 4'd1;
                if (r_rnd == LAST_RND) begin
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                w_we         = 1'b1;
                w_waddr      = LAST_KEY_IDX;
                w_wdata      = ke_key;
                w_next_rnd   = '0;
                w_next_state = READY;
            end
            default: begin
                w_next_state = IDLE;
                w_next_rnd   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rnd        <= '0;
            r_keys_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_rnd   <= w_next_rnd;
            r_done  <= (r_state == CAPTURE);
            if (w_accept) begin
                r_keys_valid <= 1'b0;
            end else if (r_state == CAPTURE) begin
                r_keys_valid <= 1'b1;
            end
        end
    end

    aes_rk_buffer u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (rk_addr),
        .o_rdata (rk_data),
        .o_key0  (w_key0)
    );

    assign keys_valid  = r_keys_valid;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule
